agc_stim_sequencer: RTL and testbench
=====================================

Name: agc_stim_sequencer

Overview:
- Parametrised, synthesizable timed-event sequencer that drives NCH discrete AGC input lines (STRT1, SA13, MSTP, MON_n, …) from a loadable event table.
- Replaces hand-written delay scripts in AGC simulation harnesses.
- Sits between bench/host loader and agc top-level input pins; adds per-line pulse generation, idle-level control, looping and abort.

Parameters:
- NCH, 16, number of driven lines
- DEPTH, 32, event table entries
- DLY_W, 24, delay counter width in CLOCK cycles
- PW_W, 8, pulse-width counter width
- INIT_LEVEL, {NCH{1'b0}}, idle/reset level per line (1 for active-low lines such as MON_n)

Ports:
- CLOCK  in  1  system clock
- SIM_RST_n  in  1  reset, synchronous, active-low
- LD_VALID  in  1  table write request
- LD_READY  out  1  table accepts write
- LD_DELAY  in  DLY_W  cycles from previous event
- LD_CHAN  in  clog2(NCH)  target line
- LD_OP  in  2  0 SET, 1 CLR, 2 PULSE, 3 TOGGLE
- LD_PW  in  PW_W  pulse width in cycles, PULSE only
- LD_CLR  in  1  empty table
- RUN  in  1  rising edge starts playback
- ABORT  in  1  stop playback
- LOOP  in  1  wrap to entry 0 after last entry
- DRIVE  out  NCH  driven line levels
- BUSY  out  1  playback active
- DONE  out  1  playback completed
- EVT_STB  out  1  one-cycle strobe when an event is applied
- EVT_IDX  out  clog2(DEPTH)  index of last applied event
- COUNT  out  clog2(DEPTH+1)  entries loaded

Behaviour:
- Clock and reset: one clock, CLOCK. Reset SIM_RST_n is synchronous and active-low.
- Reset values: DRIVE=INIT_LEVEL; COUNT=0; BUSY=0; DONE=0; EVT_STB=0; EVT_IDX=0; LD_READY=1; FSM=IDLE; all pulse timers cleared. Reset mid-run behaves identically.
- Loading:
  - Handshake completes on LD_VALID&LD_READY. Entry is written at COUNT, and COUNT increments.
  - LD_READY = (state==IDLE) && COUNT<DEPTH. Writes while full or busy are ignored.
  - LD_CLR in IDLE sets COUNT=0 and DONE=0. LD_CLR wins over a same-cycle write. LD_CLR is ignored when not IDLE.
- FSM states: IDLE, WAIT, FIRE, DRAIN.
  - IDLE -> WAIT: on RUN rising edge with COUNT>0. Loads timer = max(LD_DELAY[0],1)-1, clears DONE, sets BUSY. RUN rising edge with COUNT=0 sets DONE the next cycle.
  - WAIT: decrement timer. At 0 -> FIRE.
  - FIRE: apply entry idx. DRIVE update and EVT_STB/EVT_IDX are registered, so visible after this edge.
    - idx<COUNT-1: idx++, reload timer from next entry, -> WAIT.
    - Last entry with LOOP=1: idx=0, -> WAIT.
    - Last entry with LOOP=0: -> DRAIN.
  - Timing: event k becomes visible exactly max(d_k,1) cycles after event k-1, or after the RUN-edge cycle for k=0. d=0 is treated as 1.
  - DRAIN: wait until no pulse timer is active, then -> IDLE. BUSY=0 and DONE=1 are set on the same edge. DONE holds until the next RUN edge, LD_CLR or reset.
- Ops on line c:
  - SET: c=1.
  - CLR: c=0.
  - TOGGLE: c=~c.
  - PULSE: c=~INIT_LEVEL[c] for max(PW,1) cycles, then c returns to INIT_LEVEL[c].
  - SET/CLR/TOGGLE cancel any pending pulse on c.
  - PULSE on a line with a pulse pending restarts its timer without a glitch.
  - Pulse expiry and a new event on the same line in the same cycle: the new event wins.
  - Independent lines pulse concurrently.
- ABORT in any non-IDLE state: next edge DRIVE=INIT_LEVEL, timers cleared, -> IDLE, BUSY=0, DONE=0. ABORT beats FIRE in the same cycle: the event is not applied and there is no EVT_STB.
- LOOP is sampled only at the last-entry FIRE. Deasserting LOOP finishes the current pass.

Decomposition:
- Shared package agc_stim_pkg: op encoding constants, FSM state typedef, entry struct {delay, chan, op, pw}.
- Sub-module agc_stim_pulse_ch: one per line. Holds level register and pulse counter, applies op, exposes active flag. Instantiated NCH times via generate.

Test Plan:
- Reset: SIM_RST_n low 2 cycles with INIT_LEVEL=16'h0100 -> DRIVE=16'h0100, COUNT=0, LD_READY=1, BUSY=0.
- Load {d=50,ch0,PULSE,pw=5}, {d=200,ch12,SET}, {d=200,ch12,CLR}; RUN edge at cycle T:
  - DRIVE[0]=1 for cycles T+50..T+54.
  - DRIVE[12]=1 for cycles T+250..T+449.
  - DONE=1 at T+451 (DRAIN adds one cycle).
  - 3 EVT_STBs with EVT_IDX 0,1,2.
- Boundaries: d=0 entry fires 1 cycle after the previous event. PW=0 gives a 1-cycle pulse. Loading DEPTH+1 entries leaves COUNT=DEPTH and the extra write is not accepted (LD_READY=0).
- Pulse retrigger: PULSE ch3 pw=10, then PULSE ch3 pw=10 at d=4 -> ch3 high continuously for 14 cycles. A CLR 2 cycles into a pulse -> line low immediately, no later restore.
- LOOP=1 with 2 entries of d=10 TOGGLE ch1 -> ch1 toggles every 10 cycles indefinitely and DONE stays 0. Dropping LOOP -> DONE after the current pass.
- ABORT mid-WAIT and in a FIRE cycle -> DRIVE=INIT_LEVEL next edge, no EVT_STB, BUSY=0, DONE=0. Reset asserted mid-pulse -> same plus COUNT=0.

Source files
------------

// File: rtl/agc_stim_pkg.sv
// Shared encodings for the AGC stimulus sequencer: event opcodes and playback FSM states.
package agc_stim_pkg;

    typedef enum logic [1:0] {
        OP_SET    = 2'd0,
        OP_CLR    = 2'd1,
        OP_PULSE  = 2'd2,
        OP_TOGGLE = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FIRE  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

endpackage

// File: rtl/agc_stim_pulse_ch.sv
// One driven line: level register plus pulse timer; ops take effect on the edge after apply_vld.
// No backpressure: apply_vld is always accepted, and a new op overrides a same-cycle pulse expiry.
module agc_stim_pulse_ch
    import agc_stim_pkg::*;
#(
    parameter int   PW_W = 8,
    parameter logic INIT = 1'b0
) (
    input  logic            core_clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            apply_vld,
    input  op_e             op,
    input  logic [PW_W-1:0] pw,
    output logic            level,
    output logic            active
);

    logic [PW_W-1:0] pw_cnt;

    always_ff @(posedge core_clk) begin
        if (!rst_n || flush) begin
            level  <= INIT;
            pw_cnt <= '0;
        end else if (apply_vld) begin
            case (op)
                OP_SET: begin
                    level  <= 1'b1;
                    pw_cnt <= '0;
                end
                OP_CLR: begin
                    level  <= 1'b0;
                    pw_cnt <= '0;
                end
                OP_TOGGLE: begin
                    level  <= ~level;
                    pw_cnt <= '0;
                end
                default: begin
                    // Retrigger keeps the line asserted and just reloads the width.
                    level  <= ~INIT;
                    pw_cnt <= (pw == '0) ? PW_W'(1) : pw;
                end
            endcase
        end else if (pw_cnt != '0) begin
            pw_cnt <= pw_cnt - PW_W'(1);
            if (pw_cnt == PW_W'(1)) begin
                level <= INIT;
            end
        end
    end

    assign active = (pw_cnt != '0);

endmodule

// File: rtl/agc_stim_sequencer.sv
// Timed-event sequencer driving NCH AGC input lines from a loadable table; event k lands max(d_k,1) cycles after k-1.
// Loader is held off (LD_READY low) while playing or when the table is full; ABORT returns all lines to idle level.
module agc_stim_sequencer
    import agc_stim_pkg::*;
#(
    parameter int             NCH        = 16,
    parameter int             DEPTH      = 32,
    parameter int             DLY_W      = 24,
    parameter int             PW_W       = 8,
    parameter logic [NCH-1:0] INIT_LEVEL = '0,
    localparam int            CH_W       = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int            IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int            CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic             CLOCK,
    input  logic             SIM_RST_n,
    input  logic             LD_VALID,
    output logic             LD_READY,
    input  logic [DLY_W-1:0] LD_DELAY,
    input  logic [CH_W-1:0]  LD_CHAN,
    input  logic [1:0]       LD_OP,
    input  logic [PW_W-1:0]  LD_PW,
    input  logic             LD_CLR,
    input  logic             RUN,
    input  logic             ABORT,
    input  logic             LOOP,
    output logic [NCH-1:0]   DRIVE,
    output logic             BUSY,
    output logic             DONE,
    output logic             EVT_STB,
    output logic [IDX_W-1:0] EVT_IDX,
    output logic [CNT_W-1:0] COUNT
);

    typedef struct packed {
        logic [DLY_W-1:0] delay;
        logic [CH_W-1:0]  chan;
        op_e              op;
        logic [PW_W-1:0]  pw;
    } entry_t;

    entry_t           tbl [DEPTH];
    state_e           state;
    logic [IDX_W-1:0] idx;
    logic [DLY_W-1:0] timer;
    logic             run_q;

    logic             run_rise;
    logic             ld_take;
    logic             last;
    logic             fire_vld;
    logic             flush;
    logic [IDX_W-1:0] nxt_idx;
    logic [DLY_W-1:0] first_m1;
    logic [DLY_W-1:0] nxt_m1;
    logic [NCH-1:0]   ch_active;

    // Timer holds cycles remaining in WAIT before the FIRE cycle; d=0 behaves as d=1.
    function automatic logic [DLY_W-1:0] dly_m1(input logic [DLY_W-1:0] d);
        return (d == '0) ? '0 : d - DLY_W'(1);
    endfunction

    assign LD_READY = (state == ST_IDLE) && (COUNT < CNT_W'(DEPTH));
    assign ld_take  = LD_VALID && LD_READY && !LD_CLR;
    assign run_rise = RUN && !run_q;
    assign last     = ((CNT_W'(idx) + CNT_W'(1)) == COUNT);
    assign nxt_idx  = last ? '0 : idx + IDX_W'(1);
    assign first_m1 = dly_m1(tbl[0].delay);
    assign nxt_m1   = dly_m1(tbl[nxt_idx].delay);
    assign fire_vld = (state == ST_FIRE) && !ABORT;
    assign flush    = (state != ST_IDLE) && ABORT;

    always_ff @(posedge CLOCK) begin
        if (ld_take) begin
            tbl[COUNT[IDX_W-1:0]] <= '{delay: LD_DELAY, chan: LD_CHAN, op: op_e'(LD_OP), pw: LD_PW};
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!SIM_RST_n) begin
            state   <= ST_IDLE;
            idx     <= '0;
            timer   <= '0;
            run_q   <= 1'b0;
            COUNT   <= '0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            EVT_STB <= 1'b0;
            EVT_IDX <= '0;
        end else begin
            run_q   <= RUN;
            EVT_STB <= 1'b0;
            if (flush) begin
                state <= ST_IDLE;
                BUSY  <= 1'b0;
                DONE  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (LD_CLR) begin
                            COUNT <= '0;
                            DONE  <= 1'b0;
                        end else begin
                            if (ld_take) begin
                                COUNT <= COUNT + CNT_W'(1);
                            end
                            if (run_rise && COUNT != '0) begin
                                idx   <= '0;
                                timer <= first_m1;
                                state <= (first_m1 == '0) ? ST_FIRE : ST_WAIT;
                                BUSY  <= 1'b1;
                                DONE  <= 1'b0;
                            end else if (run_rise) begin
                                DONE <= 1'b1;
                            end
                        end
                    end
                    ST_WAIT: begin
                        timer <= timer - DLY_W'(1);
                        if (timer == DLY_W'(1)) begin
                            state <= ST_FIRE;
                        end
                    end
                    ST_FIRE: begin
                        EVT_STB <= 1'b1;
                        EVT_IDX <= idx;
                        // LOOP only matters here; nxt_idx already wraps to 0 on the last entry.
                        if (!last || LOOP) begin
                            idx   <= nxt_idx;
                            timer <= nxt_m1;
                            state <= (nxt_m1 == '0) ? ST_FIRE : ST_WAIT;
                        end else begin
                            state <= ST_DRAIN;
                        end
                    end
                    default: begin
                        if (ch_active == '0) begin
                            state <= ST_IDLE;
                            BUSY  <= 1'b0;
                            DONE  <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        agc_stim_pulse_ch #(
            .PW_W (PW_W),
            .INIT (INIT_LEVEL[i])
        ) u_ch (
            .core_clk  (CLOCK),
            .rst_n     (SIM_RST_n),
            .flush     (flush),
            .apply_vld (fire_vld && (tbl[idx].chan == CH_W'(i))),
            .op        (tbl[idx].op),
            .pw        (tbl[idx].pw),
            .level     (DRIVE[i]),
            .active    (ch_active[i])
        );
    end

endmodule

// File: tb/tb_agc_stim_sequencer.sv
// Scoreboard bench: directed runs push expected events; a negedge monitor checks every EVT_STB.
module tb_agc_stim_sequencer;

    logic        CLOCK = 1'b0;
    logic        SIM_RST_n;
    logic        LD_VALID;
    logic        LD_READY;
    logic [23:0] LD_DELAY;
    logic [3:0]  LD_CHAN;
    logic [1:0]  LD_OP;
    logic [7:0]  LD_PW;
    logic        LD_CLR;
    logic        RUN;
    logic        ABORT;
    logic        LOOP;
    logic [15:0] DRIVE;
    logic        BUSY;
    logic        DONE;
    logic        EVT_STB;
    logic [4:0]  EVT_IDX;
    logic [5:0]  COUNT;

    agc_stim_sequencer #(
        .NCH(16), .DEPTH(32), .DLY_W(24), .PW_W(8), .INIT_LEVEL(16'h0100)
    ) dut (
        .CLOCK(CLOCK), .SIM_RST_n(SIM_RST_n),
        .LD_VALID(LD_VALID), .LD_READY(LD_READY), .LD_DELAY(LD_DELAY),
        .LD_CHAN(LD_CHAN), .LD_OP(LD_OP), .LD_PW(LD_PW), .LD_CLR(LD_CLR),
        .RUN(RUN), .ABORT(ABORT), .LOOP(LOOP),
        .DRIVE(DRIVE), .BUSY(BUSY), .DONE(DONE),
        .EVT_STB(EVT_STB), .EVT_IDX(EVT_IDX), .COUNT(COUNT)
    );

    always #5 CLOCK = ~CLOCK;

    int cyc = 0;
    always @(posedge CLOCK) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int idx;
        int drv;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input int c, input int i, input int d);
        exp_q.push_back('{cyc: c, idx: i, drv: d});
    endtask

    always @(negedge CLOCK) begin : mon
        exp_t e;
        if (SIM_RST_n === 1'b1 && EVT_STB === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL evt_unexpected: strobe idx=%0d drive=0x%0h with nothing expected (cycle %0d)",
                         EVT_IDX, DRIVE, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("evt_cycle", cyc, e.cyc);
                chk("evt_idx", 32'(EVT_IDX), e.idx);
                chk("evt_drive", 32'(DRIVE), e.drv);
            end
        end
    end

    task automatic wait_to(input int n);
        while (cyc < n) @(negedge CLOCK);
    endtask

    task automatic load(input int d, input int ch, input int op, input int pw);
        LD_DELAY = 24'(d);
        LD_CHAN  = 4'(ch);
        LD_OP    = 2'(op);
        LD_PW    = 8'(pw);
        LD_VALID = 1'b1;
        @(negedge CLOCK);
        LD_VALID = 1'b0;
    endtask

    task automatic clr();
        LD_CLR = 1'b1;
        @(negedge CLOCK);
        LD_CLR = 1'b0;
    endtask

    // Returns the edge index at which the DUT sees the RUN rising edge.
    task automatic start(output int e0);
        RUN = 1'b1;
        e0  = cyc + 1;
        @(negedge CLOCK);
        RUN = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int e0;
        int hi;
        SIM_RST_n = 1'b0;
        LD_VALID  = 1'b0;
        LD_DELAY  = '0;
        LD_CHAN   = '0;
        LD_OP     = '0;
        LD_PW     = '0;
        LD_CLR    = 1'b0;
        RUN       = 1'b0;
        ABORT     = 1'b0;
        LOOP      = 1'b0;
        repeat (2) @(negedge CLOCK);
        chk("rst_drive", 32'(DRIVE), 32'h0100);
        chk("rst_count", 32'(COUNT), 0);
        chk("rst_ld_ready", 32'(LD_READY), 1);
        chk("rst_busy", 32'(BUSY), 0);
        chk("rst_done", 32'(DONE), 0);
        chk("rst_evt_stb", 32'(EVT_STB), 0);
        chk("rst_evt_idx", 32'(EVT_IDX), 0);
        SIM_RST_n = 1'b1;
        @(negedge CLOCK);

        // Pulse, set, clear with long delays.
        load(50, 0, 2, 5);
        load(200, 12, 0, 0);
        load(200, 12, 1, 0);
        chk("load3_count", 32'(COUNT), 3);
        start(e0);
        push(e0 + 50, 0, 32'h0101);
        push(e0 + 250, 1, 32'h1100);
        push(e0 + 450, 2, 32'h0100);
        chk("run_busy", 32'(BUSY), 1);
        chk("run_ld_ready", 32'(LD_READY), 0);
        wait_to(e0 + 49);  chk("p0_before", 32'(DRIVE[0]), 0);
        wait_to(e0 + 50);  chk("p0_first", 32'(DRIVE[0]), 1);
        wait_to(e0 + 54);  chk("p0_last", 32'(DRIVE[0]), 1);
        wait_to(e0 + 55);  chk("p0_after", 32'(DRIVE[0]), 0);
        wait_to(e0 + 449); chk("ch12_last_high", 32'(DRIVE[12]), 1);
        wait_to(e0 + 450); chk("done_early", 32'(DONE), 0);
        wait_to(e0 + 451); chk("done_drain", 32'(DONE), 1);
        chk("busy_end", 32'(BUSY), 0);
        chk("q_empty_main", exp_q.size(), 0);

        // d=0 and pw=0 boundaries.
        clr();
        chk("clr_count", 32'(COUNT), 0);
        chk("clr_done", 32'(DONE), 0);
        load(5, 2, 2, 0);
        load(0, 4, 0, 0);
        start(e0);
        push(e0 + 5, 0, 32'h0104);
        push(e0 + 6, 1, 32'h0110);
        wait_to(e0 + 6); chk("pw0_one_cycle", 32'(DRIVE[2]), 0);
        chk("d0_done_early", 32'(DONE), 0);
        wait_to(e0 + 7); chk("d0_done", 32'(DONE), 1);

        // Table full.
        clr();
        for (int i = 0; i < 32; i++) load(1, 5, 0, 0);
        chk("full_count", 32'(COUNT), 32);
        chk("full_ld_ready", 32'(LD_READY), 0);
        load(1, 5, 0, 0);
        chk("overfill_count", 32'(COUNT), 32);

        // Pulse retrigger, then a pulse cancelled by CLR.
        clr();
        load(3, 3, 2, 10);
        load(4, 3, 2, 10);
        load(20, 6, 2, 8);
        load(2, 6, 1, 0);
        start(e0);
        push(e0 + 3, 0, 32'h0118);
        push(e0 + 7, 1, 32'h0118);
        push(e0 + 27, 2, 32'h0150);
        push(e0 + 29, 3, 32'h0110);
        hi = 0;
        for (int k = 2; k <= 18; k++) begin
            wait_to(e0 + k);
            if (DRIVE[3] === 1'b1) hi++;
        end
        chk("retrigger_high_cycles", hi, 14);
        wait_to(e0 + 30);
        chk("cancel_done", 32'(DONE), 1);
        chk("cancel_ch6", 32'(DRIVE[6]), 0);

        // Looping toggles, then LOOP dropped.
        clr();
        load(10, 1, 3, 0);
        load(10, 1, 3, 0);
        LOOP = 1'b1;
        start(e0);
        for (int k = 1; k <= 6; k++)
            push(e0 + 10 * k, (k - 1) % 2, (k % 2 == 1) ? 32'h0112 : 32'h0110);
        wait_to(e0 + 45);
        chk("loop_done", 32'(DONE), 0);
        chk("loop_busy", 32'(BUSY), 1);
        LOOP = 1'b0;
        wait_to(e0 + 60); chk("unloop_done_early", 32'(DONE), 0);
        wait_to(e0 + 61); chk("unloop_done", 32'(DONE), 1);
        chk("q_empty_loop", exp_q.size(), 0);

        // ABORT mid-WAIT.
        start(e0);
        push(e0 + 10, 0, 32'h0112);
        wait_to(e0 + 15);
        ABORT = 1'b1;
        @(negedge CLOCK);
        ABORT = 1'b0;
        chk("abort_wait_drive", 32'(DRIVE), 32'h0100);
        chk("abort_wait_busy", 32'(BUSY), 0);
        chk("abort_wait_done", 32'(DONE), 0);

        // ABORT during the FIRE cycle of the first event.
        start(e0);
        wait_to(e0 + 9);
        ABORT = 1'b1;
        @(negedge CLOCK);
        ABORT = 1'b0;
        chk("abort_fire_stb", 32'(EVT_STB), 0);
        chk("abort_fire_drive", 32'(DRIVE), 32'h0100);
        chk("abort_fire_busy", 32'(BUSY), 0);
        chk("abort_fire_done", 32'(DONE), 0);
        chk("abort_ld_ready", 32'(LD_READY), 1);

        // Reset mid-pulse.
        clr();
        load(2, 9, 2, 20);
        start(e0);
        push(e0 + 2, 0, 32'h0300);
        wait_to(e0 + 5);
        SIM_RST_n = 1'b0;
        @(negedge CLOCK);
        chk("rst_mid_drive", 32'(DRIVE), 32'h0100);
        chk("rst_mid_count", 32'(COUNT), 0);
        chk("rst_mid_busy", 32'(BUSY), 0);
        chk("rst_mid_done", 32'(DONE), 0);
        chk("rst_mid_ld_ready", 32'(LD_READY), 1);
        SIM_RST_n = 1'b1;
        repeat (3) @(negedge CLOCK);
        chk("rst_mid_stays_idle", 32'(DRIVE), 32'h0100);
        chk("q_empty_final", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
